// File: rtl/literal_scan.sv
// literal_scan: serialises the literal fields {a,b,c,d} MSB-first after a
// start handshake and reports per-scan statistics (count of 1 bits, count of
// x/z bits, sign and magnitude of the signed field c).
//
// Optional feature macro: LITERAL_SCAN_XZ_EN
//   defined   : x/z bits are detected with case equality, counted in xz_cnt
//               and passed through unchanged on ser_bit.
//   undefined : xz_cnt is tied to 0 and any bit that is not 1 leaves as 0.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start, abort     begin a scan (IDLE only) / cancel a running scan
//   a, b, c, d       literal fields, sampled only when a scan is accepted
//   busy             scan in progress
//   ser_valid/bit    serial stream, one bit per cycle, MSB of {a,b,c,d} first
//   done             one-cycle pulse, results valid
//   ones_cnt/xz_cnt  bit statistics of the scanned word
//   c_neg/c_mag      sign and two's-complement magnitude of captured c
module literal_scan #(
    parameter  int AW = 8,
    parameter  int BW = 16,
    parameter  int CW = 4,
    parameter  int DW = 5,
    localparam int TW = AW + BW + CW + DW,
    localparam int NW = $clog2(TW + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    input  logic [CW-1:0] c,
    input  logic [DW-1:0] d,
    output logic          busy,
    output logic          ser_valid,
    output logic          ser_bit,
    output logic          done,
    output logic [NW-1:0] ones_cnt,
    output logic [NW-1:0] xz_cnt,
    output logic          c_neg,
    output logic [CW-1:0] c_mag
);

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} state_t;

    localparam logic [NW-1:0] LAST = NW'(TW - 1);

    state_t          state, state_nxt;
    logic [TW-1:0]   shadow;
    logic [NW-1:0]   idx;
    logic            load, shift_en;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start wins over abort in IDLE because abort is only
    // looked at in SHIFT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (abort) state_nxt = IDLE;
                     else if (idx == LAST) state_nxt = FLUSH;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy     = (state != IDLE);
        load     = (state == IDLE) && start;
        shift_en = (state == SHIFT) && !abort;
    end

    // Datapath: shadow shifter, serial output, ones counter and c statistics.
    // An abort edge shifts nothing, so the counters keep the partial values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            idx       <= '0;
            ser_valid <= 1'b0;
            ser_bit   <= 1'b0;
            done      <= 1'b0;
            ones_cnt  <= '0;
            c_neg     <= 1'b0;
            c_mag     <= '0;
        end else begin
            done <= (state == FLUSH);
            if (load) begin
                shadow    <= {a, b, c, d};
                c_neg     <= c[CW-1];
                // Most-negative value wraps back to itself (no saturation).
                c_mag     <= c[CW-1] ? CW'(~c + 1'b1) : c;
                ones_cnt  <= '0;
                idx       <= '0;
                ser_valid <= 1'b0;
            end else if (shift_en) begin
                ser_valid <= 1'b1;
                shadow    <= {shadow[TW-2:0], 1'b0};
                idx       <= idx + 1'b1;
`ifdef LITERAL_SCAN_XZ_EN
                ser_bit <= shadow[TW-1];
                if (shadow[TW-1] === 1'b1) ones_cnt <= ones_cnt + 1'b1;
`else
                // An x/z bit makes the condition unknown and takes the else
                // branch, so only a genuine 1 is counted or emitted as 1.
                if (shadow[TW-1] == 1'b1) begin
                    ser_bit  <= 1'b1;
                    ones_cnt <= ones_cnt + 1'b1;
                end else begin
                    ser_bit  <= 1'b0;
                end
`endif
            end else begin
                ser_valid <= 1'b0;
            end
        end
    end

`ifdef LITERAL_SCAN_XZ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            xz_cnt <= '0;
        else if (load)
            xz_cnt <= '0;
        else if (shift_en && ((shadow[TW-1] === 1'bx) || (shadow[TW-1] === 1'bz)))
            xz_cnt <= xz_cnt + 1'b1;
    end
`else
    assign xz_cnt = '0;
`endif

endmodule

// File: tb/tb_literal_scan.sv
module tb_literal_scan;
    localparam int AW = 8, BW = 16, CW = 4, DW = 5;
    localparam int TW = AW + BW + CW + DW;
    localparam int NW = $clog2(TW + 1);

    logic          clk = 1'b0;
    logic          rst_n, start, abort;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic          busy, ser_valid, ser_bit, done, c_neg;
    logic [NW-1:0] ones_cnt, xz_cnt;
    logic [CW-1:0] c_mag;

    literal_scan #(.AW(AW), .BW(BW), .CW(CW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a(a), .b(b), .c(c), .d(d),
        .busy(busy), .ser_valid(ser_valid), .ser_bit(ser_bit), .done(done),
        .ones_cnt(ones_cnt), .xz_cnt(xz_cnt), .c_neg(c_neg), .c_mag(c_mag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         ones;
        int         xz;
        logic       cn;
        logic [3:0] cm;
        int         e0;
    } res_t;

    res_t sb_res[$];
    logic sb_bits[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: statistics straight from the definition of the word.
    function automatic res_t model(input logic [TW-1:0] v);
        res_t       r;
        logic [3:0] cf;
        int         cv;
        r.ones = 0;
        r.xz   = 0;
        for (int i = TW - 1; i >= 0; i--) begin
            if (v[i] === 1'b1) r.ones++;
`ifdef LITERAL_SCAN_XZ_EN
            else if (v[i] !== 1'b0) r.xz++;
`endif
        end
        cf   = v[DW +: CW];
        cv   = int'($signed(cf));
        r.cn = (cv < 0);
        r.cm = 4'((cv < 0) ? -cv : cv);
        r.e0 = cyc;
        return r;
    endfunction

    function automatic int ones_in_first(input logic [TW-1:0] v, input int k);
        int n = 0;
        for (int i = 0; i < k; i++) if (v[TW-1-i] === 1'b1) n++;
        return n;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issues start before the next edge (E0), then queues the expectations
    // and scrambles the inputs to show they are no longer sampled.
    task automatic start_scan(input logic [AW-1:0] ia, input logic [BW-1:0] ib,
                              input logic [CW-1:0] ic, input logic [DW-1:0] id,
                              output logic [TW-1:0] v);
        a = ia; b = ib; c = ic; d = id;
        v = {ia, ib, ic, id};
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        sb_res.push_back(model(v));
        for (int i = TW - 1; i >= 0; i--) begin
`ifdef LITERAL_SCAN_XZ_EN
            sb_bits.push_back(v[i]);
`else
            sb_bits.push_back(v[i] === 1'b1);
`endif
        end
        a = AW'($urandom); b = BW'($urandom); c = CW'($urandom); d = DW'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      {31'b0, busy},      0);
        check({tag, "_ser_valid"}, {31'b0, ser_valid}, 0);
        check({tag, "_ser_bit"},   {31'b0, ser_bit},   0);
        check({tag, "_done"},      {31'b0, done},      0);
        check({tag, "_ones_cnt"},  32'(ones_cnt),      0);
        check({tag, "_xz_cnt"},    32'(xz_cnt),        0);
        check({tag, "_c_neg"},     {31'b0, c_neg},     0);
        check({tag, "_c_mag"},     32'(c_mag),         0);
    endtask

    // Monitor: consumes expectations whenever the DUT presents output.
    logic eb;
    res_t er;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ser_valid) begin
                if (sb_bits.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ser_unexpected: ser_valid 1 required 0");
                end else begin
                    eb = sb_bits.pop_front();
                    check("ser_bit", {31'b0, ser_bit}, {31'b0, eb});
                end
            end
            if (done) begin
                if (sb_res.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: done 1 required 0");
                end else begin
                    er = sb_res.pop_front();
                    check("ones_cnt", 32'(ones_cnt), er.ones);
                    check("xz_cnt",   32'(xz_cnt),   er.xz);
                    check("c_neg",    {31'b0, c_neg}, {31'b0, er.cn});
                    check("c_mag",    32'(c_mag),    32'(er.cm));
                    check("latency",  cyc - er.e0,   TW + 1);
                end
            end
        end
    end

    logic [TW-1:0] v;
    res_t          ra;
    logic [BW-1:0] bx;
    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;
        cycles(1);

`ifdef LITERAL_SCAN_XZ_EN
        bx = 16'hxxxx;
`else
        bx = 16'h0000;
`endif
        // Directed, then back-to-back all-ones with the most-negative c.
        start_scan(8'h7B, bx, 4'hE, 5'h14, v);
        cycles(TW + 1);
        start_scan(8'hFF, 16'hFFFF, 4'b1000, 5'h1F, v);
        cycles(TW + 1);
        cycles(2);

        // Re-pulsed start during a scan is ignored.
        start_scan(AW'($urandom), BW'($urandom), CW'($urandom), DW'($urandom), v);
        cycles(4);  start = 1'b1; cycles(1); start = 1'b0;
        cycles(14); start = 1'b1; cycles(1); start = 1'b0;
        cycles(14);
        check("busy_in_done_cycle", {31'b0, busy}, 0);
        cycles(3);

        // Abort after nine shifted bits.
        start_scan(AW'($urandom), BW'($urandom), CW'($urandom), DW'($urandom), v);
        ra = sb_res[sb_res.size() - 1];
        cycles(9);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        check("abort_busy",      {31'b0, busy},      0);
        check("abort_ser_valid", {31'b0, ser_valid}, 0);
        check("abort_ones_cnt",  32'(ones_cnt),      ones_in_first(v, 9));
        check("abort_c_neg",     {31'b0, c_neg},     {31'b0, ra.cn});
        check("abort_c_mag",     32'(c_mag),         32'(ra.cm));
        sb_bits.delete();
        void'(sb_res.pop_back());
        cycles(3);

        // Start and abort together in IDLE: start wins.
        abort = 1'b1;
        start_scan(AW'($urandom), BW'($urandom), 4'b0111, DW'($urandom), v);
        abort = 1'b0;
        check("start_wins_busy", {31'b0, busy}, 1);
        cycles(TW + 1);
        cycles(2);

        // Asynchronous reset mid-scan.
        start_scan(AW'($urandom), BW'($urandom), CW'($urandom), DW'($urandom), v);
        cycles(16);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        sb_bits.delete();
        sb_res.delete();
        cycles(2);
        #2 rst_n = 1'b1;
        cycles(1);
        start_scan(AW'($urandom), BW'($urandom), CW'($urandom), DW'($urandom), v);
        cycles(TW + 1);

        // Random scans with random idle gaps (gap 0 = back-to-back).
        for (int k = 0; k < 6; k++) begin
            cycles($urandom_range(0, 3));
            start_scan(AW'($urandom), BW'($urandom), CW'($urandom), DW'($urandom), v);
            cycles(TW + 1);
        end

        for (int t = 0; t < 100 && (sb_res.size() != 0 || sb_bits.size() != 0); t++) cycles(1);
        check("drain_res",  sb_res.size(),  0);
        check("drain_bits", sb_bits.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
